counter_sequence_monitor: RTL

COUNTER_SEQUENCE_MONITOR -- requirements
Module: counter_sequence_monitor

---
 rtl/counter_sequence_monitor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/counter_sequence_monitor.sv
// Watches a free-running 3-bit up counter, locks onto a clean count sequence,
// and reports wraps and sequence violations through registered outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | first edge after reset: capture q as reference
// ACQUIRE | counting consecutive correct increments toward LOCK_LEN
// LOCKED  | sequence trusted; wraps counted, mismatches flagged
// FAULT   | single cycle after a violation, then back to ACQUIRE
module counter_sequence_monitor #(
    parameter int LOCK_LEN = 2,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        q,
    input  logic              clr,
    output logic              locked,
    output logic              wrap,
    output logic              err,
    output logic [3:0]        err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [2:0] LOCK_N = 3'(LOCK_LEN);

    state_t              state_q, state_d;
    logic [2:0]          prev_q, prev_d;
    logic [2:0]          good_q, good_d;
    logic                locked_q, locked_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
    logic [3:0]          err_cnt_q, err_cnt_d;
    logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
    logic [2:0]          expected;
    logic                match;

    assign expected = prev_q + 3'd1;
    assign match    = (q == expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_q     <= 3'd0;
            good_q     <= 3'd0;
            locked_q   <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 4'd0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_q     <= good_d;
            locked_q   <= locked_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = q;
        good_d     = good_q;
        wrap_d     = 1'b0;
        // clr wipes the counters first so a coinciding event lands on zero
        err_d      = clr ? 1'b0 : err_q;
        err_cnt_d  = clr ? 4'd0 : err_cnt_q;
        wrap_cnt_d = clr ? '0   : wrap_cnt_q;

        case (state_q)
            IDLE: begin
                good_d  = 3'd0;
                state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (match) begin
                    good_d = good_q + 3'd1;
                    if (good_q + 3'd1 == LOCK_N) begin
                        state_d = LOCKED;
                    end
                end else begin
                    good_d = 3'd0;
                end
            end
            LOCKED: begin
                if (match) begin
                    if (prev_q == 3'd7) begin
                        wrap_d     = 1'b1;
                        wrap_cnt_d = wrap_cnt_d + 1'b1;
                    end
                end else begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                    if (err_cnt_d != 4'd15) begin
                        err_cnt_d = err_cnt_d + 4'd1;
                    end
                end
            end
            FAULT: begin
                good_d  = 3'd0;
                state_d = ACQUIRE;
            end
            default: begin
                good_d  = 3'd0;
                state_d = IDLE;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    assign locked   = locked_q;
    assign wrap     = wrap_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule
